wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Sole owner of the register-file write port. It merges the in-order writeback from the WB stage (the output of the DatatoReg mux) with out-of-order results from a long-latency auxiliary unit such as a multiplier/divider or an uncached load return. WB writes always win the port. Auxiliary results wait in a small FIFO and drain in cycles when WB does not write. A starvation guard forces a pipeline bubble, and a pending-register mask lets the ID stage interlock on registers that still have a queued result.

## Interface
Parameters:
- DEPTH, 2: auxiliary FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 4: number of consecutive cycles a blocked FIFO head may wait before a bubble is requested; ≥1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_we  in  1  WB stage write enable (RegWrite).
- wb_addr  in  5  WB destination register.
- wb_data  in  32  WB write data (DatatoReg mux output).
- aux_valid  in  1  auxiliary result offered.
- aux_addr  in  5  auxiliary destination register.
- aux_data  in  32  auxiliary result.
- aux_ready  out  1  FIFO can accept; a transfer occurs when aux_valid && aux_ready.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- rf_src  out  1  source of this cycle's write: 0 = WB, 1 = FIFO.
- stall_req  out  1  request for the pipeline to hold and inject a WB bubble.
- pend_mask  out  32  bit r is set when register r is the destination of any valid FIFO entry.
- fifo_count  out  clog2(DEPTH)+1  number of valid entries.

## Operation
- Define wb_act = wb_we && (wb_addr != 0).
- Port selection is combinational within the cycle:
  - If wb_act, the port carries WB: rf_we=1, rf_waddr=wb_addr, rf_wdata=wb_data, rf_src=0.
  - Otherwise, if the FIFO is non-empty, the port carries the head entry: rf_we=1, rf_src=1, and the head pops at the clock edge.
  - Otherwise rf_we=0, rf_waddr=0, rf_wdata=0, rf_src=0.
- Enqueue:
  - aux_ready = !full && !reset. Readiness is registered state only; there is no pop-through while full.
  - An accepted result with aux_addr=0 is consumed and discarded, not enqueued.
  - Simultaneous push and pop in the same cycle is legal; fifo_count is unchanged.
- Ordering: FIFO entries drain strictly in arrival order. There is no bypass, so an entry accepted in cycle t can be written no earlier than t+1.
- pend_mask is the OR of the one-hot decodes of all valid entries' addresses, driven from registered state.
  - The ID stage stalls any instruction that reads or writes a pending register, so WB and the FIFO never target the same register out of order.
  - The bench asserts that wb_act && pend_mask[wb_addr] never occurs.
- Starvation guard:
  - wait_cnt increments in each cycle the FIFO is non-empty and wb_act blocks the head.
  - wait_cnt clears to 0 on any pop or when the FIFO is empty.
  - When wait_cnt reaches STARVE_LIMIT, stall_req is set at that edge (registered).
  - While stall_req=1, the pipeline holds, guarantees wb_we=0, and the head drains in that cycle.
  - stall_req clears at the edge on which that pop occurs. If wb_act is nonetheless high, stall_req stays high and wb still wins the port.

## Timing
- Reset, checked at the first edge with reset=1:
  - FIFO empty, pointers 0, fifo_count=0, wait_cnt=0, stall_req=0, pend_mask=0.
  - While reset=1, aux_ready=0 and rf_we=0 regardless of inputs.
- Reset asserted mid-operation discards all queued entries; none are written.
- Write-port outputs are combinational from the current-cycle WB inputs and registered FIFO state: zero latency for WB, one-cycle minimum for aux.
- Head-of-line latency bound: the head is written within STARVE_LIMIT+2 cycles of reaching the head, provided the pipeline honours stall_req.
- Pointers wrap modulo DEPTH. Full is fifo_count==DEPTH; empty is fifo_count==0.

## Test plan
- Reset: with wb_we=1 and aux_valid=1 held during reset, rf_we=0, aux_ready=0, stall_req=0 and pend_mask=0. On the first cycle after reset, WB (addr 5, data 0x11) writes immediately.
- Idle drain: wb_we=0; push aux (addr 3, data 0xABCD) in cycle t. In t+1: rf_we=1, rf_waddr=3, rf_wdata=0xABCD, rf_src=1. pend_mask bit 3 is set in t+1 only.
- Priority and full: with wb_act held high, push aux to addr 4 then addr 6. fifo_count reaches 2 and aux_ready=0. A third aux_valid is not accepted.
- Starvation (STARVE_LIMIT=4): hold wb_act high with one entry queued. stall_req rises after the 4th blocked cycle. The bench drops wb_we; the entry drains, and stall_req and wait_cnt return to 0 the next cycle.
- Zero and wrap handling:
  - An aux write to addr 0 is accepted and discarded; fifo_count stays 0.
  - A WB write to addr 0 lets a queued entry drain.
  - Ten alternating push/pop cycles preserve order across pointer wrap.
- Reset mid-operation: assert reset with 2 entries queued. After release fifo_count=0 and pend_mask=0, and no stale FIFO write appears.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Single owner of the register-file write port. In-order WB writes always
// win the port; long-latency auxiliary results queue in a small FIFO and
// drain in cycles where WB is idle. A starvation guard requests a pipeline
// bubble when the FIFO head has been blocked too long, and pend_mask lets
// the ID stage interlock on registers that still have a queued result.

module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      wb_we,
    input  logic [4:0]                wb_addr,
    input  logic [31:0]               wb_data,

    input  logic                      aux_valid,
    input  logic [4:0]                aux_addr,
    input  logic [31:0]               aux_data,
    output logic                      aux_ready,

    output logic                      rf_we,
    output logic [4:0]                rf_waddr,
    output logic [31:0]               rf_wdata,
    output logic                      rf_src,

    output logic                      stall_req,
    output logic [31:0]               pend_mask,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(STARVE_LIMIT);

    // FIFO storage and bookkeeping
    logic [4:0]        mem_addr [DEPTH];
    logic [31:0]       mem_data [DEPTH];
    logic [DEPTH-1:0]  slot_valid;
    logic [DEPTH-1:0]  slot_valid_next;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // Starvation guard state
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              stall_q;
    logic              stall_next;

    // Per-cycle control
    logic wb_act;
    logic empty;
    logic full;
    logic accept;
    logic push;
    logic pop;
    logic head_blocked;

    // Writes to r0 are architecturally void, so they never occupy the port.
    assign wb_act = wb_we && (wb_addr != 5'd0);

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // Readiness depends only on registered occupancy: a full FIFO does not
    // accept even if the head happens to drain this cycle.
    assign aux_ready = !full && !reset;
    assign accept    = aux_valid && aux_ready;
    // A result for r0 completes the handshake but is dropped on the floor.
    assign push      = accept && (aux_addr != 5'd0);

    assign pop          = !reset && !wb_act && !empty;
    assign head_blocked = !empty && wb_act;

    assign fifo_count = count;
    assign stall_req  = stall_q;

    // Write-port mux: WB first, then FIFO head, otherwise idle with zeros.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        rf_src   = 1'b0;
        if (!reset) begin
            if (wb_act) begin
                rf_we    = 1'b1;
                rf_waddr = wb_addr;
                rf_wdata = wb_data;
            end else if (!empty) begin
                rf_we    = 1'b1;
                rf_waddr = mem_addr[rd_ptr];
                rf_wdata = mem_data[rd_ptr];
                rf_src   = 1'b1;
            end
        end
    end

    // Next slot-valid vector: set on push, clear on pop (never the same slot).
    always_comb begin
        slot_valid_next = slot_valid;
        if (pop) begin
            slot_valid_next[rd_ptr] = 1'b0;
        end
        if (push) begin
            slot_valid_next[wr_ptr] = 1'b1;
        end
    end

    // Pending-register mask built purely from registered FIFO contents.
    always_comb begin
        pend_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i]) begin
                pend_mask[mem_addr[i]] = 1'b1;
            end
        end
    end

    // Starvation counter and bubble request, next-state view.
    always_comb begin
        wait_next = wait_cnt;
        if (pop || empty) begin
            wait_next = '0;
        end else if (head_blocked && (wait_cnt != WAIT_MAX)) begin
            wait_next = wait_cnt + 1'b1;
        end

        stall_next = stall_q;
        if (pop) begin
            stall_next = 1'b0;
        end else if (wait_next == WAIT_MAX) begin
            stall_next = 1'b1;
        end
    end

    // FIFO payload storage; only pointers and valid bits carry reset.
    always_ff @(posedge clk) begin
        // NOTE: the payload array is deliberately not reset; slot_valid and count decide what is live, and leaving data unreset keeps it mappable to plain RAM.
        if (push) begin
            mem_addr[wr_ptr] <= aux_addr;
            mem_data[wr_ptr] <= aux_data;
        end
    end

    // FIFO pointers, occupancy and valid bits.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            slot_valid <= '0;
        end else begin
            slot_valid <= slot_valid_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Starvation guard registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            stall_q  <= 1'b0;
        end else begin
            wait_cnt <= wait_next;
            stall_q  <= stall_next;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4).
// Inputs change 1ns after the rising edge; outputs are checked after a
// further 1ns settle, well away from the next active edge.

module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        aux_valid;
    logic [4:0]  aux_addr;
    logic [31:0] aux_data;
    logic        aux_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_src;
    logic        stall_req;
    logic [31:0] pend_mask;
    logic [1:0]  fifo_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .aux_valid  (aux_valid),
        .aux_addr   (aux_addr),
        .aux_data   (aux_data),
        .aux_ready  (aux_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_src     (rf_src),
        .stall_req  (stall_req),
        .pend_mask  (pend_mask),
        .fifo_count (fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // The ID-stage interlock guarantees WB never targets a pending register.
    always @(negedge clk) begin
        if (!reset && wb_we && (wb_addr != 5'd0)) begin
            check("interlock", {31'd0, pend_mask[wb_addr]}, 32'd0);
        end
    end

    initial begin
        // ---------------- reset with active inputs ----------------
        reset     = 1'b1;
        wb_we     = 1'b1;
        wb_addr   = 5'd5;
        wb_data   = 32'h11;
        aux_valid = 1'b1;
        aux_addr  = 5'd7;
        aux_data  = 32'h77;
        tick();
        check("rst_rf_we",      {31'd0, rf_we},      32'd0);
        check("rst_aux_ready",  {31'd0, aux_ready},  32'd0);
        check("rst_stall",      {31'd0, stall_req},  32'd0);
        check("rst_pend",       pend_mask,           32'd0);
        check("rst_count",      {30'd0, fifo_count}, 32'd0);
        check("rst_wait",       32'(dut.wait_cnt),   32'd0);
        tick();

        reset     = 1'b0;
        aux_valid = 1'b0;
        settle();
        check("wb_first_we",    {31'd0, rf_we},      32'd1);
        check("wb_first_addr",  {27'd0, rf_waddr},   32'd5);
        check("wb_first_data",  rf_wdata,            32'h11);
        check("wb_first_src",   {31'd0, rf_src},     32'd0);
        tick();

        // ---------------- idle drain ----------------
        wb_we     = 1'b0;
        aux_valid = 1'b1;
        aux_addr  = 5'd3;
        aux_data  = 32'hABCD;
        settle();
        check("idle_ready",     {31'd0, aux_ready},  32'd1);
        check("idle_no_bypass", {31'd0, rf_we},      32'd0);
        check("idle_pend_t",    pend_mask,           32'd0);
        tick();
        aux_valid = 1'b0;
        settle();
        check("drain_we",       {31'd0, rf_we},      32'd1);
        check("drain_addr",     {27'd0, rf_waddr},   32'd3);
        check("drain_data",     rf_wdata,            32'hABCD);
        check("drain_src",      {31'd0, rf_src},     32'd1);
        check("drain_pend",     pend_mask,           32'h0000_0008);
        check("drain_count",    {30'd0, fifo_count}, 32'd1);
        tick();
        check("drained_pend",   pend_mask,           32'd0);
        check("drained_count",  {30'd0, fifo_count}, 32'd0);
        check("drained_we",     {31'd0, rf_we},      32'd0);

        // ---------------- priority and full ----------------
        wb_we     = 1'b1;
        wb_addr   = 5'd9;
        wb_data   = 32'h99;
        aux_valid = 1'b1;
        aux_addr  = 5'd4;
        aux_data  = 32'h44;
        tick();
        aux_addr  = 5'd6;
        aux_data  = 32'h66;
        settle();
        check("prio_count1",    {30'd0, fifo_count}, 32'd1);
        check("prio_src_wb",    {31'd0, rf_src},     32'd0);
        check("prio_addr_wb",   {27'd0, rf_waddr},   32'd9);
        tick();
        aux_addr  = 5'd8;
        aux_data  = 32'h88;
        settle();
        check("full_count",     {30'd0, fifo_count}, 32'd2);
        check("full_ready",     {31'd0, aux_ready},  32'd0);
        check("full_pend",      pend_mask,           32'h0000_0050);
        tick();
        check("full_reject",    {30'd0, fifo_count}, 32'd2);
        check("full_pend_keep", pend_mask,           32'h0000_0050);
        aux_valid = 1'b0;
        wb_we     = 1'b0;
        settle();
        check("order_addr0",    {27'd0, rf_waddr},   32'd4);
        check("order_data0",    rf_wdata,            32'h44);
        check("order_src0",     {31'd0, rf_src},     32'd1);
        check("order_stall",    {31'd0, stall_req},  32'd0);
        tick();
        check("order_addr1",    {27'd0, rf_waddr},   32'd6);
        check("order_data1",    rf_wdata,            32'h66);
        tick();
        check("order_empty",    {30'd0, fifo_count}, 32'd0);

        // ---------------- starvation guard ----------------
        wb_we     = 1'b1;
        wb_addr   = 5'd11;
        wb_data   = 32'hB;
        aux_valid = 1'b1;
        aux_addr  = 5'd10;
        aux_data  = 32'hA0A0;
        tick();
        aux_valid = 1'b0;
        tick();
        tick();
        tick();
        check("starve_wait3",   32'(dut.wait_cnt),   32'd3);
        check("starve_low3",    {31'd0, stall_req},  32'd0);
        tick();
        check("starve_wait4",   32'(dut.wait_cnt),   32'd4);
        check("starve_high",    {31'd0, stall_req},  32'd1);
        check("starve_wb_wins", {31'd0, rf_src},     32'd0);
        tick();
        check("starve_hold",    {31'd0, stall_req},  32'd1);
        wb_we = 1'b0;
        settle();
        check("starve_src",     {31'd0, rf_src},     32'd1);
        check("starve_addr",    {27'd0, rf_waddr},   32'd10);
        check("starve_data",    rf_wdata,            32'hA0A0);
        tick();
        check("starve_clear",   {31'd0, stall_req},  32'd0);
        check("starve_wait0",   32'(dut.wait_cnt),   32'd0);
        check("starve_count0",  {30'd0, fifo_count}, 32'd0);

        // ---------------- zero-address handling ----------------
        aux_valid = 1'b1;
        aux_addr  = 5'd0;
        aux_data  = 32'hDEAD;
        settle();
        check("zero_ready",     {31'd0, aux_ready},  32'd1);
        tick();
        aux_valid = 1'b0;
        settle();
        check("zero_count",     {30'd0, fifo_count}, 32'd0);
        check("zero_no_write",  {31'd0, rf_we},      32'd0);

        wb_we     = 1'b1;
        wb_addr   = 5'd0;
        wb_data   = 32'hFFFF;
        aux_valid = 1'b1;
        aux_addr  = 5'd12;
        aux_data  = 32'hC;
        settle();
        check("wb0_idle",       {31'd0, rf_we},      32'd0);
        tick();
        aux_valid = 1'b0;
        settle();
        check("wb0_drain_src",  {31'd0, rf_src},     32'd1);
        check("wb0_drain_addr", {27'd0, rf_waddr},   32'd12);
        check("wb0_drain_data", rf_wdata,            32'hC);
        tick();
        check("wb0_empty",      {30'd0, fifo_count}, 32'd0);

        // ---------------- push/pop across pointer wrap ----------------
        wb_we = 1'b0;
        for (int k = 0; k < 10; k++) begin
            aux_valid = 1'b1;
            aux_addr  = 5'(13 + k);
            aux_data  = 32'h100 + 32'(k);
            settle();
            if (k > 0) begin
                check("wrap_addr",  {27'd0, rf_waddr},   32'(12 + k));
                check("wrap_data",  rf_wdata,            32'h100 + 32'(k - 1));
                check("wrap_count", {30'd0, fifo_count}, 32'd1);
            end
            tick();
        end
        aux_valid = 1'b0;
        settle();
        check("wrap_last_addr", {27'd0, rf_waddr},   32'd22);
        check("wrap_last_data", rf_wdata,            32'h109);
        tick();
        check("wrap_empty",     {30'd0, fifo_count}, 32'd0);

        // ---------------- reset mid-operation ----------------
        wb_we     = 1'b1;
        wb_addr   = 5'd25;
        wb_data   = 32'h25;
        aux_valid = 1'b1;
        aux_addr  = 5'd26;
        aux_data  = 32'h26;
        tick();
        aux_addr  = 5'd27;
        aux_data  = 32'h27;
        tick();
        check("mid_count2",     {30'd0, fifo_count}, 32'd2);
        reset = 1'b1;
        settle();
        check("mid_rst_we",     {31'd0, rf_we},      32'd0);
        check("mid_rst_ready",  {31'd0, aux_ready},  32'd0);
        tick();
        reset     = 1'b0;
        wb_we     = 1'b0;
        aux_valid = 1'b0;
        settle();
        check("mid_count0",     {30'd0, fifo_count}, 32'd0);
        check("mid_pend0",      pend_mask,           32'd0);
        check("mid_no_stale",   {31'd0, rf_we},      32'd0);
        tick();
        check("mid_no_stale2",  {31'd0, rf_we},      32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
